prog_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the instruction memory and the RISC-V core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, writes them into instruction memory through its write port, and holds the core in reset until the image is complete. It lets the same core and memory pair run new programs on hardware without re-synthesising the memory init file.

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader_if.sv | 30 +++
 rtl/prog_loader_word_asm.sv | 44 ++++
 rtl/prog_loader.sv | 155 +++++++++++++++
 tb/tb_prog_loader.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the boot-time program loader.
// Optional trailing-checksum support is enabled by defining PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_HEADER = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_START  = 3'd3,
    ST_RUN    = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam int unsigned BYTE_CNT_W = 2;

  // Bytes enter at the top and move down, so after four bytes the first one sits in [7:0].
  function automatic logic [31:0] le_shift_in(input logic [31:0] acc, input logic [7:0] data_byte);
    return {data_byte, acc[31:8]};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream, instruction-memory write and status bundle of the program loader.
// master drives the stream and reload; slave is the loader itself.
interface prog_loader_if #(
  parameter int INS_MEM_ADDR_WIDTH = 10
);
  logic                          PROG_LOADER_Byte_Valid_in;
  logic [7:0]                    PROG_LOADER_Byte_InBUS;
  logic                          PROG_LOADER_Byte_Ready_out;
  logic                          PROG_LOADER_Reload_in;
  logic                          PROG_LOADER_Insmem_We_out;
  logic [INS_MEM_ADDR_WIDTH-1:0] PROG_LOADER_Insmem_Addr_OutBUS;
  logic [31:0]                   PROG_LOADER_Insmem_Data_OutBUS;
  logic                          PROG_LOADER_Core_Reset_out;
  logic                          PROG_LOADER_Done_out;
  logic                          PROG_LOADER_Error_out;

  modport master (
    output PROG_LOADER_Byte_Valid_in, PROG_LOADER_Byte_InBUS, PROG_LOADER_Reload_in,
    input  PROG_LOADER_Byte_Ready_out, PROG_LOADER_Insmem_We_out,
           PROG_LOADER_Insmem_Addr_OutBUS, PROG_LOADER_Insmem_Data_OutBUS,
           PROG_LOADER_Core_Reset_out, PROG_LOADER_Done_out, PROG_LOADER_Error_out
  );

  modport slave (
    input  PROG_LOADER_Byte_Valid_in, PROG_LOADER_Byte_InBUS, PROG_LOADER_Reload_in,
    output PROG_LOADER_Byte_Ready_out, PROG_LOADER_Insmem_We_out,
           PROG_LOADER_Insmem_Addr_OutBUS, PROG_LOADER_Insmem_Data_OutBUS,
           PROG_LOADER_Core_Reset_out, PROG_LOADER_Done_out, PROG_LOADER_Error_out
  );
endinterface

// File: rtl/prog_loader_word_asm.sv
// Little-endian word assembler: counts accepted bytes and emits a registered
// one-cycle word_vld pulse together with the completed 32-bit word.
module prog_loader_word_asm
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  data_byte,
  output logic        word_vld,
  output logic [31:0] word
);

  logic [BYTE_CNT_W-1:0] cnt;
  logic [31:0]           shreg;
  logic [31:0]           shreg_nxt;

  assign shreg_nxt = le_shift_in(shreg, data_byte);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      shreg    <= '0;
      word_vld <= 1'b0;
      word     <= '0;
    end else if (clear) begin
      cnt      <= '0;
      shreg    <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= 1'b0;
      if (take) begin
        shreg <= shreg_nxt;
        cnt   <= cnt + 1'b1;
        if (cnt == {BYTE_CNT_W{1'b1}}) begin
          word_vld <= 1'b1;
          word     <= shreg_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: header word N, N data words written to instruction
// memory, core released after a one-cycle START. PROG_LOADER_CHECKSUM_EN adds a trailing sum word.
//
// state     | meaning
// HEADER    | collecting word count N
// LOAD      | collecting and writing data words
// CHECK     | collecting trailing checksum word
// START     | one settling cycle after the last write
// RUN       | image loaded, core out of reset
// ERROR     | load failed, core held in reset
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATAWIDTH          = 32,
  parameter int INS_MEM_ADDR_WIDTH = 10
) (
  input  logic           PROG_LOADER_Clk_in,
  input  logic           PROG_LOADER_Reset_in,
  prog_loader_if.slave   bus
);

  localparam int unsigned MAXW  = 1 << (INS_MEM_ADDR_WIDTH - 2);
  localparam int          IDX_W = $clog2(MAXW) + 1;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_LOAD = ST_CHECK;
`else
  localparam state_t ST_AFTER_LOAD = ST_START;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 reload;
  logic                 ready;
  logic                 take;
  logic                 word_vld;
  logic [DATAWIDTH-1:0] word;
  logic                 hdr_over;
  logic                 last_word;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [IDX_W-1:0]     n_words, n_words_nxt;
  logic                 core_reset_q;
  logic                 done_q;
  logic                 error_q;

  assign clk    = PROG_LOADER_Clk_in;
  assign rst_n  = PROG_LOADER_Reset_in;
  assign reload = bus.PROG_LOADER_Reload_in;

  assign ready = ((state == ST_HEADER) || (state == ST_LOAD) || (state == ST_CHECK)) && !reload;
  assign take  = bus.PROG_LOADER_Byte_Valid_in && ready;

  prog_loader_word_asm u_word_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (reload),
    .take      (take),
    .data_byte (bus.PROG_LOADER_Byte_InBUS),
    .word_vld  (word_vld),
    .word      (word)
  );

  assign hdr_over  = word > DATAWIDTH'(MAXW);
  assign last_word = idx == (n_words - IDX_W'(1));

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATAWIDTH-1:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (reload) begin
      sum <= '0;
    end else if (word_vld) begin
      if (state == ST_HEADER) begin
        sum <= word;
      end else if (state == ST_LOAD) begin
        sum <= sum + word;
      end
    end
  end
`endif

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    n_words_nxt = n_words;
    if (reload) begin
      state_nxt = ST_HEADER;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_HEADER: begin
          if (word_vld) begin
            // Only meaningful when N <= MAXW, which always fits in IDX_W bits.
            n_words_nxt = word[IDX_W-1:0];
            if (hdr_over) begin
              state_nxt = ST_ERROR;
            end else if (word == '0) begin
              state_nxt = ST_AFTER_LOAD;
            end else begin
              state_nxt = ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (word_vld) begin
            idx_nxt = idx + 1'b1;
            if (last_word) begin
              state_nxt = ST_AFTER_LOAD;
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (word_vld) begin
            state_nxt = (word == sum) ? ST_START : ST_ERROR;
          end
        end
`endif
        ST_START: state_nxt = ST_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_HEADER;
      idx          <= '0;
      n_words      <= '0;
      core_reset_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      n_words      <= n_words_nxt;
      core_reset_q <= (state_nxt == ST_RUN);
      done_q       <= (state_nxt == ST_RUN);
      error_q      <= (state_nxt == ST_ERROR);
    end
  end

  assign bus.PROG_LOADER_Byte_Ready_out     = ready;
  assign bus.PROG_LOADER_Insmem_We_out      = word_vld && (state == ST_LOAD);
  assign bus.PROG_LOADER_Insmem_Addr_OutBUS = {idx[IDX_W-2:0], 2'b00};
  assign bus.PROG_LOADER_Insmem_Data_OutBUS = word;
  assign bus.PROG_LOADER_Core_Reset_out     = core_reset_q;
  assign bus.PROG_LOADER_Done_out           = done_q;
  assign bus.PROG_LOADER_Error_out          = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios with random data words
// and random stalls, checked against an image-level model of the expected writes.
module tb_prog_loader;

  localparam int AW   = 10;
  localparam int MAXW = 1 << (AW - 2);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prog_loader_if #(.INS_MEM_ADDR_WIDTH(AW)) bus ();

  prog_loader #(
    .DATAWIDTH          (32),
    .INS_MEM_ADDR_WIDTH (AW)
  ) dut (
    .PROG_LOADER_Clk_in   (clk),
    .PROG_LOADER_Reset_in (rst_n),
    .bus                  (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          last_we_cyc   = 0;
  int          core_rise_cyc = 0;
  logic        core_prev     = 1'b0;

  logic [31:0] stream_q[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [31:0] fixed_q[$];
  bit          exp_err;

  always @(negedge clk) begin
    if (bus.PROG_LOADER_Insmem_We_out === 1'b1) begin
      wr_addr_q.push_back(32'(bus.PROG_LOADER_Insmem_Addr_OutBUS));
      wr_data_q.push_back(bus.PROG_LOADER_Insmem_Data_OutBUS);
      last_we_cyc = cyc;
    end
    if (bus.PROG_LOADER_Core_Reset_out === 1'b1 && core_prev !== 1'b1) core_rise_cyc = cyc;
    core_prev = bus.PROG_LOADER_Core_Reset_out;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_errs);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference image: header, data words, optional trailing sum; expected writes at word*4.
  task automatic make_image(input logic [31:0] n, input bit bad_sum);
    logic [31:0] s;
    logic [31:0] w;
    stream_q = {};
    exp_a    = {};
    exp_d    = {};
    stream_q.push_back(n);
    s = n;
    if (n > 32'(MAXW)) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      w = (fixed_q.size() > i) ? fixed_q[i] : $urandom;
      stream_q.push_back(w);
      exp_a.push_back(32'(i * 4));
      exp_d.push_back(w);
      s = s + w;
    end
    exp_err = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    if (bad_sum) stream_q.push_back((s != 32'h0) ? 32'h0 : 32'h1);
    else         stream_q.push_back(s);
    exp_err = bad_sum;
`else
    if (bad_sum) exp_err = 1'b0;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall_max);
    bit ok;
    ok = 1'b0;
    repeat ($urandom_range(0, stall_max)) @(negedge clk);
    bus.PROG_LOADER_Byte_Valid_in = 1'b1;
    bus.PROG_LOADER_Byte_InBUS    = b;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (bus.PROG_LOADER_Byte_Ready_out === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
      if (ok) break;
    end
    bus.PROG_LOADER_Byte_Valid_in = 1'b0;
    if (!ok) chk("byte_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_words(input int first, input int nbytes, input int stall_max);
    logic [31:0] w;
    int sent;
    sent = 0;
    for (int i = first; i < stream_q.size(); i++) begin
      w = stream_q[i];
      for (int k = 0; k < 4; k++) begin
        if (nbytes >= 0 && sent >= nbytes) return;
        send_byte(w[8*k +: 8], stall_max);
        sent++;
      end
    end
  endtask

  task automatic clear_log();
    wr_addr_q = {};
    wr_data_q = {};
  endtask

  task automatic reload_pulse();
    bus.PROG_LOADER_Reload_in = 1'b1;
    @(negedge clk);
    bus.PROG_LOADER_Reload_in = 1'b0;
    clear_log();
  endtask

  task automatic wait_settle();
    for (int t = 0; t < 40; t++) begin
      if (bus.PROG_LOADER_Done_out === 1'b1 || bus.PROG_LOADER_Error_out === 1'b1) break;
      @(negedge clk);
    end
    #1;
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s_wr%0d_addr", tag, i), wr_addr_q[i], exp_a[i]);
      chk($sformatf("%s_wr%0d_data", tag, i), wr_data_q[i], exp_d[i]);
    end
    chk({tag, "_done"},  32'(bus.PROG_LOADER_Done_out),       32'(!exp_err));
    chk({tag, "_error"}, 32'(bus.PROG_LOADER_Error_out),      32'(exp_err));
    chk({tag, "_core"},  32'(bus.PROG_LOADER_Core_Reset_out), 32'(!exp_err));
    chk({tag, "_ready"}, 32'(bus.PROG_LOADER_Byte_Ready_out), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},    32'(bus.PROG_LOADER_Insmem_We_out),      32'd0);
    chk({tag, "_addr"},  32'(bus.PROG_LOADER_Insmem_Addr_OutBUS), 32'd0);
    chk({tag, "_data"},  bus.PROG_LOADER_Insmem_Data_OutBUS,      32'd0);
    chk({tag, "_done"},  32'(bus.PROG_LOADER_Done_out),           32'd0);
    chk({tag, "_error"}, 32'(bus.PROG_LOADER_Error_out),          32'd0);
    chk({tag, "_core"},  32'(bus.PROG_LOADER_Core_Reset_out),     32'd0);
  endtask

  logic [31:0] last_addr;

  initial begin
    bus.PROG_LOADER_Byte_Valid_in = 1'b0;
    bus.PROG_LOADER_Byte_InBUS    = 8'h00;
    bus.PROG_LOADER_Reload_in     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.PROG_LOADER_Byte_Ready_out), 32'd1);
    @(negedge clk);

    // Basic two-word load
    fixed_q = {32'h00500093, 32'h00108113};
    make_image(32'd2, 1'b0);
    clear_log();
    send_words(0, -1, 0);
    wait_settle();
    check_result("basic");
`ifndef PROG_LOADER_CHECKSUM_EN
    chk("basic_release_delay", 32'(core_rise_cyc - last_we_cyc), 32'd2);
`endif

    // Reload from RUN, then a one-word image
    @(negedge clk);
    bus.PROG_LOADER_Reload_in = 1'b1;
    @(posedge clk);
    #1;
    chk("reload_core", 32'(bus.PROG_LOADER_Core_Reset_out), 32'd0);
    chk("reload_done", 32'(bus.PROG_LOADER_Done_out), 32'd0);
    @(negedge clk);
    bus.PROG_LOADER_Reload_in = 1'b0;
    clear_log();
    fixed_q = {32'hDEADBEEF};
    make_image(32'd1, 1'b0);
    send_words(0, -1, 1);
    wait_settle();
    check_result("reload_run");

`ifdef PROG_LOADER_CHECKSUM_EN
    reload_pulse();
    fixed_q = {32'h00500093, 32'h00108113};
    make_image(32'd2, 1'b1);
    send_words(0, -1, 0);
    wait_settle();
    check_result("bad_sum");
`endif
    fixed_q = {};

    // Oversize headers
    reload_pulse();
    make_image(32'h00000101, 1'b0);
    send_words(0, -1, 2);
    wait_settle();
    check_result("over_101");

    reload_pulse();
    make_image(32'h80000000 | $urandom, 1'b0);
    send_words(0, -1, 2);
    wait_settle();
    check_result("over_big");

    // Empty image
    reload_pulse();
    make_image(32'd0, 1'b0);
    send_words(0, -1, 1);
    wait_settle();
    check_result("empty");

    // Byte offered together with Reload mid-header must be dropped
    reload_pulse();
    make_image(32'd3, 1'b0);
    send_words(0, 2, 1);
    bus.PROG_LOADER_Reload_in     = 1'b1;
    bus.PROG_LOADER_Byte_Valid_in = 1'b1;
    bus.PROG_LOADER_Byte_InBUS    = 8'hAA;
    #1;
    chk("ready_on_reload", 32'(bus.PROG_LOADER_Byte_Ready_out), 32'd0);
    @(negedge clk);
    bus.PROG_LOADER_Reload_in     = 1'b0;
    bus.PROG_LOADER_Byte_Valid_in = 1'b0;
    clear_log();
    send_words(0, -1, 3);
    wait_settle();
    check_result("reload_byte");

    // Full-capacity image
    reload_pulse();
    make_image(32'(MAXW), 1'b0);
    send_words(0, -1, 1);
    wait_settle();
    check_result("full");
    last_addr = (wr_addr_q.size() > 0) ? wr_addr_q[wr_addr_q.size()-1] : 32'hFFFFFFFF;
    chk("full_last_addr", last_addr, 32'h000003FC);

    // Random small images with random stalls
    for (int r = 0; r < 4; r++) begin
      reload_pulse();
      make_image(32'($urandom_range(1, 12)), 1'b0);
      send_words(0, -1, 3);
      wait_settle();
      check_result($sformatf("rand%0d", r));
    end

    // Async reset after the third byte of the second data word
    reload_pulse();
    make_image(32'd3, 1'b0);
    send_words(0, 11, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    make_image(32'd2, 1'b0);
    send_words(0, -1, 2);
    wait_settle();
    check_result("after_arst");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
